// File: rtl/circuit_operand_sequencer.sv
// Operand/result sequencer for the netlist datapath: registers one operand triple,
// waits LAT cycles for the datapath to settle, then holds the captured result until it is consumed.
module circuit_operand_sequencer #(
   parameter int DATAW = 8,
   parameter int XW    = 16,
   parameter int LAT   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DATAW-1:0] in_a,
   input  logic [DATAW-1:0] in_b,
   input  logic [DATAW-1:0] in_c,
   output logic [DATAW-1:0] dp_a,
   output logic [DATAW-1:0] dp_b,
   output logic [DATAW-1:0] dp_c,
   input  logic [DATAW-1:0] dp_z,
   input  logic [XW-1:0]    dp_x,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DATAW-1:0] out_z,
   output logic [XW-1:0]    out_x,
   output logic [15:0]      txn_count
);

   if (LAT < 0 || LAT > 15) begin : g_lat_chk
      $error("circuit_operand_sequencer: LAT must be within 0..15");
   end

   localparam logic [3:0] LAT4 = 4'(LAT);

   typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

   state_t     state;
   logic [3:0] wcnt;

   // in_ready/out_valid are registered alongside state so they never depend on inputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         wcnt      <= '0;
         dp_a      <= '0;
         dp_b      <= '0;
         dp_c      <= '0;
         out_z     <= '0;
         out_x     <= '0;
         txn_count <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  dp_a     <= in_a;
                  dp_b     <= in_b;
                  dp_c     <= in_c;
                  wcnt     <= LAT4;
                  in_ready <= 1'b0;
                  state    <= WAIT;
               end
            end
            WAIT: begin
               if (wcnt != 4'd0) begin
                  wcnt <= wcnt - 4'd1;
               end else begin
                  out_z     <= dp_z;
                  out_x     <= dp_x;
                  out_valid <= 1'b1;
                  state     <= HOLD;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  txn_count <= txn_count + 16'd1;
                  state     <= IDLE;
               end
            end
            default: begin
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_circuit_operand_sequencer.sv
// Directed bench: three sequencers (LAT=1, 0, 15) share stimulus, each driving a
// delay-line datapath model (z=a+b, x=a*c signed) whose result appears LAT cycles after dp_* change.
module tb_circuit_operand_sequencer;

   logic        clk, rst;
   logic        in_valid, out_ready;
   logic [7:0]  in_a, in_b, in_c;
   logic        in_ready [3];
   logic        out_valid [3];
   logic [7:0]  dp_a [3], dp_b [3], dp_c [3], dp_z [3], out_z [3];
   logic [15:0] dp_x [3], out_x [3], txn_count [3];
   logic [15:0] exp_cnt [3];
   int          lats [3];
   int          nchk, nerr;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int L = (g == 0) ? 1 : (g == 1) ? 0 : 15;
      logic [7:0]  z0;
      logic [15:0] x0;
      logic [7:0]  zp [1:15];
      logic [15:0] xp [1:15];

      always_comb begin
         z0 = dp_a[g] + dp_b[g];
         x0 = {{8{dp_a[g][7]}}, dp_a[g]} * {{8{dp_c[g][7]}}, dp_c[g]};
      end

      // Stale values sit in the line until LAT edges pass, so an early capture is visible.
      always_ff @(posedge clk) begin
         zp[1] <= z0;
         xp[1] <= x0;
         for (int k = 2; k < 16; k++) begin
            zp[k] <= zp[k-1];
            xp[k] <= xp[k-1];
         end
      end

      if (L == 0) begin : g_comb
         assign dp_z[g] = z0;
         assign dp_x[g] = x0;
      end else begin : g_reg
         assign dp_z[g] = zp[L];
         assign dp_x[g] = xp[L];
      end

      circuit_operand_sequencer #(.DATAW(8), .XW(16), .LAT(L)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid),
         .in_ready  (in_ready[g]),
         .in_a      (in_a),
         .in_b      (in_b),
         .in_c      (in_c),
         .dp_a      (dp_a[g]),
         .dp_b      (dp_b[g]),
         .dp_c      (dp_c[g]),
         .dp_z      (dp_z[g]),
         .dp_x      (dp_x[g]),
         .out_valid (out_valid[g]),
         .out_ready (out_ready),
         .out_z     (out_z[g]),
         .out_x     (out_x[g]),
         .txn_count (txn_count[g])
      );
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One transaction on all three instances; hold = cycles of withheld out_ready.
   task automatic xact(input logic [7:0] a, b, c, z, input logic [15:0] x, input int hold);
      int  k;
      int  seen [3];
      for (int g = 0; g < 3; g++) chk($sformatf("acc_rdy%0d", g), 32'(in_ready[g]), 1);
      in_valid = 1'b1; in_a = a; in_b = b; in_c = c;
      @(negedge clk);
      in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00; in_c = 8'h00;
      for (int g = 0; g < 3; g++) begin
         chk($sformatf("dp_a%0d", g), 32'(dp_a[g]), 32'(a));
         chk($sformatf("dp_c%0d", g), 32'(dp_c[g]), 32'(c));
         seen[g] = 0;
      end
      k = 0;
      while (k < 40 && (seen[0] == 0 || seen[1] == 0 || seen[2] == 0)) begin
         @(negedge clk);
         k++;
         for (int g = 0; g < 3; g++) if (seen[g] == 0 && out_valid[g]) seen[g] = k;
      end
      for (int g = 0; g < 3; g++) begin
         chk($sformatf("lat%0d", g), 32'(seen[g]), 32'(lats[g] + 1));
         chk($sformatf("out_z%0d", g), 32'(out_z[g]), 32'(z));
         chk($sformatf("out_x%0d", g), 32'(out_x[g]), 32'(x));
      end
      for (int h = 0; h < hold; h++) begin
         in_valid = 1'b1; in_a = 8'h09;
         @(negedge clk);
         for (int g = 0; g < 3; g++) begin
            chk($sformatf("bp_vld%0d", g), 32'(out_valid[g]), 1);
            chk($sformatf("bp_z%0d", g), 32'(out_z[g]), 32'(z));
            chk($sformatf("bp_x%0d", g), 32'(out_x[g]), 32'(x));
            chk($sformatf("bp_rdy%0d", g), 32'(in_ready[g]), 0);
            chk($sformatf("bp_dpa%0d", g), 32'(dp_a[g]), 32'(a));
         end
      end
      in_valid = 1'b0; in_a = 8'h00;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      for (int g = 0; g < 3; g++) begin
         exp_cnt[g] = exp_cnt[g] + 16'd1;
         chk($sformatf("done_vld%0d", g), 32'(out_valid[g]), 0);
         chk($sformatf("done_rdy%0d", g), 32'(in_ready[g]), 1);
         chk($sformatf("cnt%0d", g), 32'(txn_count[g]), 32'(exp_cnt[g]));
      end
      if (hold > 0) begin
         repeat (3) @(negedge clk);
         for (int g = 0; g < 3; g++) chk($sformatf("cnt_once%0d", g), 32'(txn_count[g]), 32'(exp_cnt[g]));
      end
   endtask

   initial begin
      nchk = 0; nerr = 0;
      lats[0] = 1; lats[1] = 0; lats[2] = 15;
      for (int g = 0; g < 3; g++) exp_cnt[g] = 16'h0000;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_a = 8'h00; in_b = 8'h00; in_c = 8'h00;

      // reset state
      @(negedge clk);
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
         chk($sformatf("rst_rdy%0d", g), 32'(in_ready[g]), 1);
         chk($sformatf("rst_vld%0d", g), 32'(out_valid[g]), 0);
         chk($sformatf("rst_dp%0d", g), {8'h00, dp_a[g], dp_b[g], dp_c[g]}, 0);
         chk($sformatf("rst_oz%0d", g), 32'(out_z[g]), 0);
         chk($sformatf("rst_ox%0d", g), 32'(out_x[g]), 0);
         chk($sformatf("rst_cnt%0d", g), 32'(txn_count[g]), 0);
      end
      rst = 1'b0;
      repeat (10) begin
         @(negedge clk);
         for (int g = 0; g < 3; g++) begin
            chk($sformatf("idle_rdy%0d", g), 32'(in_ready[g]), 1);
            chk($sformatf("idle_vld%0d", g), 32'(out_valid[g]), 0);
         end
      end

      // reset while in WAIT discards the transaction
      in_valid = 1'b1; in_a = 8'h05; in_b = 8'h03; in_c = 8'h02;
      @(negedge clk);
      in_valid = 1'b0;
      for (int g = 0; g < 3; g++) chk($sformatf("wait_rdy%0d", g), 32'(in_ready[g]), 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (20) begin
         @(negedge clk);
         for (int g = 0; g < 3; g++) chk($sformatf("mid_vld%0d", g), 32'(out_valid[g]), 0);
      end
      for (int g = 0; g < 3; g++) begin
         chk($sformatf("mid_cnt%0d", g), 32'(txn_count[g]), 0);
         chk($sformatf("mid_rdy%0d", g), 32'(in_ready[g]), 1);
         chk($sformatf("mid_dpa%0d", g), 32'(dp_a[g]), 0);
      end

      xact(8'h05, 8'h03, 8'h02, 8'h08, 16'h000A, 0);
      xact(8'hFD, 8'h01, 8'h04, 8'hFE, 16'hFFF4, 0);
      xact(8'h7F, 8'h01, 8'hFF, 8'h80, 16'hFF81, 0);
      xact(8'h10, 8'h20, 8'hFE, 8'h30, 16'hFFE0, 20);

      // preload the counter near its wrap point instead of running 65534 transactions
      force g_dut[0].u_dut.txn_count = 16'hFFFE;
      @(negedge clk);
      release g_dut[0].u_dut.txn_count;
      exp_cnt[0] = 16'hFFFE;
      @(negedge clk);
      xact(8'h01, 8'h01, 8'h01, 8'h02, 16'h0001, 0);
      xact(8'h80, 8'h80, 8'h02, 8'h00, 16'hFF00, 0);
      chk("wrap_zero", 32'(txn_count[0]), 0);

      $display("TB_RESULT checks=%0d failures=%0d", nchk, nerr);
      $finish;
   end

endmodule
